// File: rtl/fp_sweep_sequencer.sv
// Segment-table sweep sequencer for the fp_counter ramp generator. Each segment
// issues len step_en pulses at the prescaled tick rate, running once or looping.
module fp_sweep_sequencer #(
  parameter int NSEG  = 8,
  parameter int LEN_W = 16,
  parameter int PRE_W = 16,
  localparam int SEG_W = $clog2(NSEG)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             loop_en,
  input  logic [SEG_W-1:0] last_seg,
  input  logic [PRE_W-1:0] prescale,
  input  logic             tbl_we,
  input  logic [SEG_W-1:0] tbl_addr,
  input  logic [8+LEN_W-1:0] tbl_wdata,
  output logic             ctr_clr,
  output logic [7:0]       step,
  output logic             step_en,
  output logic             busy,
  output logic             done,
  output logic [SEG_W-1:0] seg_idx
);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN} state_t;
  typedef struct packed {
    logic [LEN_W-1:0] len;
    logic [7:0]       step;
  } seg_t;

  state_t           state, state_nxt;
  seg_t             tbl [NSEG];
  logic [PRE_W-1:0] pre_q, presc_cnt;
  logic [SEG_W-1:0] last_q;
  logic [LEN_W-1:0] seg_cnt, cur_len;
  logic [7:0]       cur_step;
  logic             tick, seg_end, is_last;

  assign tick    = (presc_cnt == pre_q);
  assign is_last = (seg_idx == last_q);
  // a zero-length segment ends on its first RUN cycle without a pulse
  assign seg_end = (state == RUN) &&
                   ((cur_len == '0) || (tick && (seg_cnt == cur_len - LEN_W'(1))));
  assign step    = cur_step;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !abort) state_nxt = CLEAR;
      CLEAR:   state_nxt = abort ? IDLE : RUN;
      RUN:     if (abort || (seg_end && is_last && !loop_en)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ctr_clr = (state == CLEAR);
    busy    = (state == CLEAR) || (state == RUN);
    step_en = (state == RUN) && tick && (cur_len != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NSEG; i++) tbl[i] <= '0;
      pre_q     <= '0;
      last_q    <= '0;
      presc_cnt <= '0;
      seg_cnt   <= '0;
      seg_idx   <= '0;
      cur_len   <= '0;
      cur_step  <= '0;
      done      <= 1'b0;
    end else begin
      if (tbl_we) tbl[tbl_addr] <= seg_t'(tbl_wdata);
      done <= 1'b0;
      case (state)
        IDLE: if (start && !abort) begin
          pre_q  <= prescale;
          last_q <= last_seg;
        end
        CLEAR: if (!abort) begin
          seg_idx   <= '0;
          cur_len   <= tbl[0].len;
          cur_step  <= tbl[0].step;
          presc_cnt <= '0;
          seg_cnt   <= '0;
        end
        RUN: if (!abort) begin
          if (seg_end) begin
            presc_cnt <= '0;
            seg_cnt   <= '0;
            if (!is_last) begin
              seg_idx  <= seg_idx + SEG_W'(1);
              cur_len  <= tbl[seg_idx + SEG_W'(1)].len;
              cur_step <= tbl[seg_idx + SEG_W'(1)].step;
            end else if (loop_en) begin
              seg_idx  <= '0;
              cur_len  <= tbl[0].len;
              cur_step <= tbl[0].step;
            end else begin
              done <= 1'b1;
            end
          end else begin
            presc_cnt <= tick ? '0 : presc_cnt + PRE_W'(1);
            if (step_en) seg_cnt <= seg_cnt + LEN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
